// File: rtl/sram_turn_scheduler.sv
// sram_turn_scheduler: registered time-slot arbiter for the shared external SRAM.
// Video has priority, CPU/aux alternate round-robin, and a starvation counter limits video runs.
module sram_turn_scheduler #(
    parameter int AW           = 19,
    parameter int ACC_CYCLES   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [7:0]    aux_wdata,
    output logic          aux_ack,
    output logic [7:0]    aux_rdata,
    output logic [AW-1:0] sram_a,
    output logic          sram_we_n,
    output logic [7:0]    sram_dout,
    output logic          sram_doe,
    input  logic [7:0]    sram_din
);
    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
    localparam int KW = $clog2(ACC_CYCLES);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [KW-1:0] K_LAST = KW'(ACC_CYCLES - 1);
    localparam logic [CW-1:0] C_LIM = CW'(STARVE_LIMIT);
    localparam logic [1:0] OWN_VID = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic [1:0]    own_q, own_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] a_q, a_d;
    logic [7:0]    dout_q, dout_d;
    logic          we_n_q, we_n_d, doe_q, doe_d;
    logic [2:0]    ack_q, ack_d;
    logic [7:0]    vrd_q, vrd_d, crd_q, crd_d, ard_q, ard_d;
    logic          v_pend, c_pend, a_pend, o_pend, gnt_v, gnt_o, pick_aux, rd_smp;

    // A requester whose ack is showing this cycle is still holding req, so it is masked out.
    always_comb begin
        v_pend   = vid_req & ~ack_q[0];
        c_pend   = cpu_req & ~ack_q[1];
        a_pend   = aux_req & ~ack_q[2];
        o_pend   = c_pend | a_pend;
        gnt_v    = (state_q == IDLE) && v_pend && ((cnt_q < C_LIM) || !o_pend);
        gnt_o    = (state_q == IDLE) && !gnt_v && o_pend;
        pick_aux = rr_q ? a_pend : !c_pend;
        rd_smp   = (state_q == ACCESS) && (k_q == K_LAST) && !wr_q;
        state_d  = state_q;
        k_d      = k_q;
        own_d    = own_q;
        wr_d     = wr_q;
        a_d      = a_q;
        dout_d   = dout_q;
        rr_d     = rr_q;
        ack_d    = '0;
        if (gnt_v) begin
            state_d = ACCESS;
            k_d     = '0;
            own_d   = OWN_VID;
            wr_d    = 1'b0;
            a_d     = vid_addr;
        end else if (gnt_o) begin
            state_d = ACCESS;
            k_d     = '0;
            own_d   = pick_aux ? OWN_AUX : OWN_CPU;
            wr_d    = pick_aux ? aux_we : cpu_we;
            a_d     = pick_aux ? aux_addr : cpu_addr;
            dout_d  = pick_aux ? aux_wdata : cpu_wdata;
            rr_d    = !pick_aux;
        end else if (state_q == ACCESS) begin
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                state_d = wr_q ? TURN : IDLE;
                ack_d   = 3'b001 << own_q;
            end
        end else if (state_q == TURN) begin
            state_d = IDLE;
        end
        vrd_d  = (rd_smp && own_q == OWN_VID) ? sram_din : vrd_q;
        crd_d  = (rd_smp && own_q == OWN_CPU) ? sram_din : crd_q;
        ard_d  = (rd_smp && own_q == OWN_AUX) ? sram_din : ard_q;
        cnt_d  = (!o_pend || gnt_o) ? '0 : gnt_v ? cnt_q + 1'b1 : cnt_q;
        we_n_d = !((state_d == ACCESS) && wr_d && (k_d != '0));
        doe_d  = (state_d == ACCESS) && wr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            own_q   <= OWN_VID;
            wr_q    <= 1'b0;
            a_q     <= '0;
            dout_q  <= '0;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
            ack_q   <= '0;
            vrd_q   <= '0;
            crd_q   <= '0;
            ard_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            vrd_q   <= vrd_d;
            crd_q   <= crd_d;
            ard_q   <= ard_d;
        end
    end

    assign vid_ack   = ack_q[0];
    assign cpu_ack   = ack_q[1];
    assign aux_ack   = ack_q[2];
    assign vid_rdata = vrd_q;
    assign cpu_rdata = crd_q;
    assign aux_rdata = ard_q;
    assign sram_a    = a_q;
    assign sram_we_n = we_n_q;
    assign sram_dout = dout_q;
    assign sram_doe  = doe_q;
endmodule

// File: tb/tb_sram_turn_scheduler.sv
// tb_sram_turn_scheduler: directed scenarios plus random traffic against a timeline reference model.
module tb_sram_turn_scheduler;
    localparam int AW = 19, ACC = 2, SL = 4, NEG = -100;

    logic clk = 0, rst = 1;
    logic vid_req = 0, cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
    logic [AW-1:0] vid_addr = 0, cpu_addr = 0, aux_addr = 0;
    logic [7:0] cpu_wdata = 0, aux_wdata = 0, sram_din = 0;
    logic vid_ack, cpu_ack, aux_ack, sram_we_n, sram_doe;
    logic [7:0] vid_rdata, cpu_rdata, aux_rdata, sram_dout;
    logic [AW-1:0] sram_a;

    always #5 clk = ~clk;

    sram_turn_scheduler #(.AW(AW), .ACC_CYCLES(ACC), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .sram_a(sram_a), .sram_we_n(sram_we_n), .sram_dout(sram_dout), .sram_doe(sram_doe),
        .sram_din(sram_din)
    );

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: each grant is a point in time g; every output follows from offsets to g.
    bit chk_en = 0;
    int cyc = 0, g = NEG, gwho = 0, cnt = 0, busy_end;
    bit gwr = 0, rr_aux = 0, v, c, a, oth, acc;
    logic [AW-1:0] last_a = 0, e_a = 0;
    logic [7:0] gd = 0;
    logic [7:0] rd [3];
    bit e_we_n = 1, e_doe = 0;
    bit [2:0] e_ack = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sram_a", sram_a, e_a);
            check("sram_we_n", sram_we_n, e_we_n);
            check("sram_doe", sram_doe, e_doe);
            if (e_doe) check("sram_dout", sram_dout, gd);
            check("acks", {aux_ack, cpu_ack, vid_ack}, e_ack);
            check("vid_rdata", vid_rdata, rd[0]);
            check("cpu_rdata", cpu_rdata, rd[1]);
            check("aux_rdata", aux_rdata, rd[2]);
        end
        if (rst) begin
            g = NEG; gwr = 0; cnt = 0; rr_aux = 0; last_a = 0;
            rd[0] = 0; rd[1] = 0; rd[2] = 0;
        end else begin
            if (cyc == g + ACC && !gwr) rd[gwho] = sram_din;
            v = vid_req && !e_ack[0];
            c = cpu_req && !e_ack[1];
            a = aux_req && !e_ack[2];
            oth = c || a;
            busy_end = g + ACC + (gwr ? 1 : 0);
            if (cyc > busy_end && v && (cnt < SL || !oth)) begin
                g = cyc; gwho = 0; gwr = 0; last_a = vid_addr;
                cnt = oth ? cnt + 1 : 0;
            end else if (cyc > busy_end && oth) begin
                gwho = (rr_aux ? a : !c) ? 2 : 1;
                g = cyc; rr_aux = (gwho == 1);
                gwr = (gwho == 2) ? aux_we : cpu_we;
                last_a = (gwho == 2) ? aux_addr : cpu_addr;
                gd = (gwho == 2) ? aux_wdata : cpu_wdata;
                cnt = 0;
            end else if (!oth) cnt = 0;
        end
        acc = (cyc + 1 >= g + 1) && (cyc + 1 <= g + ACC);
        e_a = last_a;
        e_doe = acc && gwr;
        e_we_n = !(acc && gwr && (cyc + 1 > g + 1));
        e_ack = (cyc + 1 == g + ACC + 1) ? 3'b001 << gwho : 3'b000;
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] acks();
        return {aux_ack, cpu_ack, vid_ack};
    endfunction

    function automatic logic rq(input int r);
        return r == 0 ? vid_req : r == 1 ? cpu_req : aux_req;
    endfunction

    task automatic set_rq(input int r, input logic val);
        if (r == 0) vid_req = val;
        else if (r == 1) cpu_req = val;
        else aux_req = val;
    endtask

    task automatic set_req(input int r, input logic we, input logic [AW-1:0] ad, input logic [7:0] wd);
        if (r == 0) begin vid_req = 1; vid_addr = ad; end
        else if (r == 1) begin cpu_req = 1; cpu_we = we; cpu_addr = ad; cpu_wdata = wd; end
        else begin aux_req = 1; aux_we = we; aux_addr = ad; aux_wdata = wd; end
    endtask

    task automatic new_req(input int r);
        set_req(r, r == 0 ? 1'b0 : 1'($urandom_range(1)), AW'($urandom), 8'($urandom));
    endtask

    task automatic do_reset();
        vid_req = 0; cpu_req = 0; aux_req = 0; rst = 1;
        tick();
        tick();
        check("rst_sram_a", sram_a, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_doe", sram_doe, 0);
        check("rst_acks", acks(), 0);
        check("rst_rdata", {vid_rdata, cpu_rdata, aux_rdata}, 0);
        rst = 0;
        chk_en = 1;
    endtask

    task automatic do_req(input int r, input logic we, input logic [AW-1:0] ad, input logic [7:0] wd,
                          output int lat);
        logic [2:0] ak;
        set_req(r, we, ad, wd);
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            ak = acks();
            if (ak[r]) lat = i;
        end
        tick();
        set_rq(r, 0);
    endtask

    // Collects the order of acks; requesters flagged in drop release req the cycle after their ack.
    task automatic watch(input int n, input logic [2:0] drop, output int ord[4], output int when[4],
                         output int got);
        logic [2:0] pd, ak;
        pd = 0;
        got = 0;
        for (int i = 0; i < 4; i++) begin ord[i] = -1; when[i] = -1; end
        for (int i = 1; i <= 60 && got < n; i++) begin
            tick();
            for (int r = 0; r < 3; r++) if (pd[r]) set_rq(r, 0);
            pd = 0;
            ak = acks();
            for (int r = 0; r < 3; r++)
                if (ak[r] && got < 4) begin ord[got] = r; when[got] = i; got++; pd[r] = drop[r]; end
        end
        tick();
        for (int r = 0; r < 3; r++) if (pd[r]) set_rq(r, 0);
    endtask

    int lat, got;
    int ord [4];
    int when [4];
    logic [2:0] prev_ack;

    initial begin
        do_reset();
        sram_din = 8'hA5;
        do_req(1, 0, 19'h12345, 8'h00, lat);
        check("rd_latency", lat, 3);
        check("rd_addr", sram_a, 19'h12345);
        check("rd_data", cpu_rdata, 8'hA5);
        do_req(1, 1, 19'h00010, 8'h3C, lat);
        check("wr_latency", lat, 3);
        check("wr_addr", sram_a, 19'h00010);

        do_reset();
        set_req(1, 0, 19'h00100, 8'h00);
        set_req(2, 0, 19'h00200, 8'h00);
        watch(4, 3'b000, ord, when, got);
        check("alt_n", got, 4);
        check("alt0", ord[0], 1);
        check("alt1", ord[1], 2);
        check("alt2", ord[2], 1);
        check("alt3", ord[3], 2);

        do_reset();
        set_req(0, 0, 19'h00777, 8'h00);
        set_req(1, 0, 19'h00888, 8'h00);
        watch(3, 3'b010, ord, when, got);
        check("starve_first", ord[0], 0);
        check("starve_cpu", ord[1], 1);
        check("starve_bound", when[1] <= 5 * (ACC + 1) + 1, 1);
        check("starve_vid_resume", ord[2], 0);

        do_reset();
        set_req(1, 1, 19'h0ABCD, 8'h5A);
        tick();
        tick();
        check("abort_k1_we_n", sram_we_n, 0);
        check("abort_k1_doe", sram_doe, 1);
        rst = 1;
        tick();
        check("abort_we_n", sram_we_n, 1);
        check("abort_doe", sram_doe, 0);
        check("abort_a", sram_a, 0);
        check("abort_ack", cpu_ack, 0);
        rst = 0;
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            tick();
            if (cpu_ack) lat = i;
        end
        check("abort_retry_lat", lat, 3);
        tick();
        cpu_req = 0;

        do_reset();
        set_req(0, 0, 19'h01000, 8'h00);
        set_req(1, 0, 19'h02000, 8'h00);
        set_req(2, 0, 19'h03000, 8'h00);
        watch(3, 3'b111, ord, when, got);
        check("all3_0", ord[0], 0);
        check("all3_1", ord[1], 1);
        check("all3_2", ord[2], 2);
        set_req(0, 0, 19'h04000, 8'h00);
        watch(1, 3'b001, ord, when, got);
        check("all3_3", ord[0], 0);

        do_reset();
        prev_ack = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (prev_ack[r]) begin
                    if ($urandom_range(1) == 1) new_req(r);
                    else set_rq(r, 0);
                end else if (!rq(r) && $urandom_range(3) == 0) new_req(r);
            end
            sram_din = 8'($urandom);
            rst = ($urandom_range(499) == 0);
            prev_ack = acks();
            tick();
        end
        rst = 0; vid_req = 0; cpu_req = 0; aux_req = 0;
        repeat (8) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
